// File: rtl/zed_status_leds_if.sv
`default_nettype none
// ============================================================================
//  Module      : zed_status_leds_if
//  Description : Fabric-side bundle for the board-status LED engine.
//                master = fabric logic driving mode/pattern controls,
//                slave  = the LED engine producing LED drive and status.
//  Signals     : mode_load      load mode_in into the mode register
//                mode_in[1:0]   mode to load (0 static,1 heartbeat,2 walk,3 count)
//                static_pattern pattern shown in static mode
//                led            registered LED drive
//                mode_out[1:0]  current mode register
//                tick           one-cycle pulse per prescaler wrap
//                btn_pulse      one-cycle pulse on debounced button press
//  Revision    : 1.0 - initial release
// ============================================================================
interface zed_status_leds_if #(
  parameter int NUM_LEDS = 8
) ();

  logic                mode_load;
  logic [1:0]          mode_in;
  logic [NUM_LEDS-1:0] static_pattern;
  logic [NUM_LEDS-1:0] led;
  logic [1:0]          mode_out;
  logic                tick;
  logic                btn_pulse;

  modport master (
    output mode_load,
    output mode_in,
    output static_pattern,
    input  led,
    input  mode_out,
    input  tick,
    input  btn_pulse
  );

  modport slave (
    input  mode_load,
    input  mode_in,
    input  static_pattern,
    output led,
    output mode_out,
    output tick,
    output btn_pulse
  );

endinterface
`default_nettype wire

// File: rtl/zed_status_leds.sv
`default_nettype none
// ============================================================================
//  Module      : zed_status_leds
//  Description : Programmable board-status LED pattern engine. Drives
//                NUM_LEDS outputs in static, heartbeat, walking-one or
//                binary-count mode, paced by an internal prescaler. The mode
//                is advanced by a debounced push-button or loaded directly
//                from fabric logic.
//  Ports       : GCLK         system clock (single domain)
//                reset_rtl_n  synchronous active-low reset
//                btn_raw      asynchronous bouncing push-button, active high
//                bus          zed_status_leds_if.slave (mode controls in,
//                             led / mode_out / tick / btn_pulse out)
//  Revision    : 1.0 - initial release
// ============================================================================
module zed_status_leds #(
  parameter int                  NUM_LEDS        = 8,
  parameter int                  TICK_DIV        = 50_000_000,
  parameter int                  DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [NUM_LEDS-1:0] STATIC_RESET    = NUM_LEDS'('hAB)
) (
  input  wire logic         GCLK,
  input  wire logic         reset_rtl_n,
  input  wire logic         btn_raw,
  zed_status_leds_if.slave  bus
);

  localparam int c_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_STAB_W  = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
  localparam logic [c_PRESC_W-1:0] c_PRESC_ONE  = c_PRESC_W'(1);
  localparam logic [c_STAB_W-1:0]  c_STAB_LAST  = c_STAB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_STAB_W-1:0]  c_STAB_ONE   = c_STAB_W'(1);
  localparam logic [NUM_LEDS-1:0]  c_LED_ONE    = NUM_LEDS'(1);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_HEART  = 2'd1,
    MODE_WALK   = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_t;

  // Prescaler
  logic [c_PRESC_W-1:0] r_presc;
  logic                 r_tick;

  // Button synchroniser and debouncer
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_deb;
  logic [c_STAB_W-1:0]  r_stab;
  logic                 r_btn_pulse;

  // Mode and pattern
  mode_t                r_mode;
  logic [NUM_LEDS-1:0]  r_led;

  mode_t                w_mode_next;
  logic                 w_mode_change;
  logic [NUM_LEDS-1:0]  w_led_next;

  // Next mode: a direct load wins over a button press arriving in the
  // same cycle; the press is simply dropped.
  always_comb begin
    w_mode_next = r_mode;
    if (bus.mode_load) begin
      w_mode_next = mode_t'(bus.mode_in);
    end else if (r_btn_pulse) begin
      w_mode_next = mode_t'(r_mode + 2'd1);
    end
  end

  // Reloading the mode already active is not treated as a change, so the
  // running pattern keeps going.
  assign w_mode_change = (w_mode_next != r_mode);

  // Next pattern. A mode change re-initialises the pattern and swallows any
  // tick arriving in the same cycle.
  always_comb begin
    w_led_next = r_led;
    if (w_mode_change) begin
      case (w_mode_next)
        MODE_STATIC: w_led_next = bus.static_pattern;
        MODE_HEART:  w_led_next = '0;
        MODE_WALK:   w_led_next = c_LED_ONE;
        default:     w_led_next = '0;
      endcase
    end else begin
      case (r_mode)
        MODE_STATIC: w_led_next = bus.static_pattern;
        MODE_HEART: begin
          if (r_tick) w_led_next = ~r_led;
        end
        MODE_WALK: begin
          if (r_tick) w_led_next = {r_led[NUM_LEDS-2:0], r_led[NUM_LEDS-1]};
        end
        default: begin
          if (r_tick) w_led_next = r_led + c_LED_ONE;
        end
      endcase
    end
  end

  always_ff @(posedge GCLK) begin
    if (!reset_rtl_n) begin
      r_presc     <= '0;
      r_tick      <= 1'b0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_deb       <= 1'b0;
      r_stab      <= '0;
      r_btn_pulse <= 1'b0;
      r_mode      <= MODE_STATIC;
      r_led       <= STATIC_RESET;
    end else begin
      // Prescaler: the tick pulse is registered, so it is visible for the
      // one cycle that follows the wrap edge.
      if (r_presc == c_PRESC_LAST) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + c_PRESC_ONE;
      end
      r_tick <= (r_presc == c_PRESC_LAST);

      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;

      // Debouncer: count consecutive cycles where the synced level
      // disagrees with the accepted level; any agreement restarts it.
      r_btn_pulse <= 1'b0;
      if (r_sync2 != r_deb) begin
        if (r_stab == c_STAB_LAST) begin
          r_deb       <= r_sync2;
          r_stab      <= '0;
          r_btn_pulse <= r_sync2;  // press only, never release
        end else begin
          r_stab <= r_stab + c_STAB_ONE;
        end
      end else begin
        r_stab <= '0;
      end

      r_mode <= w_mode_next;
      r_led  <= w_led_next;
    end
  end

  assign bus.led       = r_led;
  assign bus.mode_out  = r_mode;
  assign bus.tick      = r_tick;
  assign bus.btn_pulse = r_btn_pulse;

endmodule
`default_nettype wire

// File: tb/tb_zed_status_leds.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zed_status_leds
//  Description : Self-checking bench for zed_status_leds. A behavioural model
//                tracks released-edge count, debounced button level and the
//                LED pattern from the functional rules; each scenario task
//                compares DUT outputs against it after every clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zed_status_leds;

  localparam int T = 4;
  localparam int D = 3;

  logic GCLK = 1'b0;
  logic reset_rtl_n;
  logic btn_raw;

  zed_status_leds_if #(.NUM_LEDS(8)) bus_if ();

  zed_status_leds #(
    .NUM_LEDS        (8),
    .TICK_DIV        (T),
    .DEBOUNCE_CYCLES (D),
    .STATIC_RESET    (8'hAB)
  ) dut (
    .GCLK        (GCLK),
    .reset_rtl_n (reset_rtl_n),
    .btn_raw     (btn_raw),
    .bus         (bus_if.slave)
  );

  always #5 GCLK = ~GCLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int         m_n;
  logic [7:0] m_led;
  int         m_mode;
  bit         m_tick;
  bit         m_pulse;
  bit         m_deb;
  int         rawq[$];
  int         synq[$];

  task automatic model_edge();
    bit prev_tick, prev_pulse, all_diff, toggled;
    int v, new_mode;
    if (!reset_rtl_n) begin
      m_n = 0; m_led = 8'hAB; m_mode = 0; m_tick = 0; m_pulse = 0; m_deb = 0;
      rawq.delete(); synq.delete();
      return;
    end
    prev_tick  = m_tick;
    prev_pulse = m_pulse;
    // Debouncer sees the raw button as sampled two edges earlier.
    v = (rawq.size() >= 2) ? rawq[rawq.size()-2] : 0;
    rawq.push_back(int'(btn_raw));
    if (rawq.size() > 3) void'(rawq.pop_front());
    synq.push_back(v);
    if (synq.size() > D) void'(synq.pop_front());
    toggled = 0;
    if (synq.size() == D) begin
      all_diff = 1;
      foreach (synq[i]) if (synq[i] == int'(m_deb)) all_diff = 0;
      toggled = all_diff;
    end
    m_pulse = toggled && (v == 1);
    if (toggled) m_deb = (v == 1);
    new_mode = bus_if.mode_load ? int'(bus_if.mode_in)
             : (prev_pulse ? (m_mode + 1) % 4 : m_mode);
    if (new_mode != m_mode) begin
      m_led = (new_mode == 0) ? bus_if.static_pattern : (new_mode == 2) ? 8'h01 : 8'h00;
    end else if (m_mode == 0) begin
      m_led = bus_if.static_pattern;
    end else if (prev_tick) begin
      case (m_mode)
        1:       m_led = ~m_led;
        2:       m_led = (m_led << 1) | (m_led >> 7);
        default: m_led = m_led + 8'd1;
      endcase
    end
    m_mode = new_mode;
    m_n++;
    m_tick = (m_n % T == 0);
  endtask

  task automatic step();
    @(posedge GCLK);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_rtl_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_if.static_pattern = 8'($urandom);
      step();
      if ({bus_if.led, bus_if.mode_out, bus_if.tick, bus_if.btn_pulse} !== {8'hAB, 2'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset: led=%h mode=%0d tick=%b pulse=%b, want led=ab mode=0 tick=0 pulse=0",
                 bus_if.led, bus_if.mode_out, bus_if.tick, bus_if.btn_pulse);
      end
      n_chk++;
    end
  endtask

  task automatic test_static();
    reset_rtl_n = 1'b1;
    bus_if.static_pattern = 8'h3C;
    step();
    if (bus_if.led !== 8'h3C) begin
      n_fail++; $display("FAIL static_first: led=%h want 3c", bus_if.led);
    end
    n_chk++;
    bus_if.static_pattern = 8'h81;
    step();
    if (bus_if.led !== 8'h81) begin
      n_fail++; $display("FAIL static_change: led=%h want 81", bus_if.led);
    end
    n_chk++;
    for (int i = 0; i < 20; i++) begin
      bus_if.static_pattern = 8'($urandom);
      step();
      if ({bus_if.led, bus_if.mode_out, bus_if.tick, bus_if.btn_pulse} !== {m_led, 2'(m_mode), m_tick, m_pulse}) begin
        n_fail++;
        $display("FAIL static_rand: led=%h mode=%0d tick=%b pulse=%b, want led=%h mode=%0d tick=%b pulse=%b",
                 bus_if.led, bus_if.mode_out, bus_if.tick, bus_if.btn_pulse, m_led, m_mode, m_tick, m_pulse);
      end
      n_chk++;
    end
  endtask

  task automatic test_heartbeat();
    int ticks = 0;
    int last = -1;
    bus_if.mode_load = 1'b1; bus_if.mode_in = 2'd1;
    step();
    bus_if.mode_load = 1'b0;
    if (bus_if.led !== 8'h00 || bus_if.mode_out !== 2'd1) begin
      n_fail++; $display("FAIL heart_load: led=%h mode=%0d want led=00 mode=1", bus_if.led, bus_if.mode_out);
    end
    n_chk++;
    for (int i = 0; i < 16; i++) begin
      step();
      if ({bus_if.led, bus_if.mode_out, bus_if.tick, bus_if.btn_pulse} !== {m_led, 2'(m_mode), m_tick, m_pulse}) begin
        n_fail++;
        $display("FAIL heart: led=%h mode=%0d tick=%b, want led=%h mode=%0d tick=%b",
                 bus_if.led, bus_if.mode_out, bus_if.tick, m_led, m_mode, m_tick);
      end
      n_chk++;
      if (bus_if.tick === 1'b1) begin
        if (last >= 0) begin
          if (i - last != T) begin
            n_fail++; $display("FAIL heart_period: got %0d cycles want %0d", i - last, T);
          end
          n_chk++;
        end
        last = i;
        ticks++;
      end
    end
    if (ticks != 16 / T) begin
      n_fail++; $display("FAIL heart_tick_count: got %0d want %0d", ticks, 16 / T);
    end
    n_chk++;
  endtask

  task automatic test_walk();
    bus_if.mode_load = 1'b1; bus_if.mode_in = 2'd2;
    step();
    bus_if.mode_load = 1'b0;
    if (bus_if.led !== 8'h01) begin
      n_fail++; $display("FAIL walk_load: led=%h want 01", bus_if.led);
    end
    n_chk++;
    for (int i = 0; i < 40; i++) begin
      step();
      if ({bus_if.led, bus_if.mode_out, bus_if.tick, bus_if.btn_pulse} !== {m_led, 2'(m_mode), m_tick, m_pulse}) begin
        n_fail++;
        $display("FAIL walk: led=%h tick=%b, want led=%h tick=%b", bus_if.led, bus_if.tick, m_led, m_tick);
      end
      n_chk++;
    end
  endtask

  task automatic test_count();
    logic [7:0] prev;
    bit wrapped = 0;
    bit found = 0;
    bus_if.mode_load = 1'b1; bus_if.mode_in = 2'd3;
    step();
    bus_if.mode_load = 1'b0;
    prev = bus_if.led;
    for (int i = 0; i < 256 * T + T; i++) begin
      step();
      if ({bus_if.led, bus_if.mode_out, bus_if.tick, bus_if.btn_pulse} !== {m_led, 2'(m_mode), m_tick, m_pulse}) begin
        n_fail++;
        $display("FAIL count: led=%h tick=%b, want led=%h tick=%b", bus_if.led, bus_if.tick, m_led, m_tick);
      end
      n_chk++;
      if (prev === 8'hFF && bus_if.led === 8'h00) wrapped = 1;
      prev = bus_if.led;
    end
    if (!wrapped) begin
      n_fail++; $display("FAIL count_wrap: ff->00 seen=%b want 1", wrapped);
    end
    n_chk++;
    for (int i = 0; i < 2 * T && !found; i++) begin
      if (bus_if.tick === 1'b1) found = 1;
      else step();
    end
    if (!found) begin
      n_fail++; $display("FAIL collision_wait: tick not seen within %0d cycles", 2 * T);
    end
    n_chk++;
    bus_if.mode_load = 1'b1; bus_if.mode_in = 2'd2;
    step();
    bus_if.mode_load = 1'b0;
    if (bus_if.led !== 8'h01 || bus_if.led !== m_led) begin
      n_fail++; $display("FAIL collision: led=%h want 01 (model %h)", bus_if.led, m_led);
    end
    n_chk++;
  endtask

  task automatic test_debounce();
    int pulses;
    bus_if.mode_load = 1'b1; bus_if.mode_in = 2'd0;
    step();
    bus_if.mode_load = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      btn_raw = (i % 2 == 0);
      step();
      if (bus_if.btn_pulse === 1'b1) pulses++;
      if ({bus_if.led, bus_if.mode_out, bus_if.btn_pulse} !== {m_led, 2'(m_mode), m_pulse}) begin
        n_fail++;
        $display("FAIL bounce: mode=%0d pulse=%b, want mode=%0d pulse=%b", bus_if.mode_out, bus_if.btn_pulse, m_mode, m_pulse);
      end
      n_chk++;
    end
    for (int i = 0; i < 4; i++) begin
      btn_raw = 1'b0;
      step();
      if (bus_if.btn_pulse === 1'b1) pulses++;
    end
    if (pulses != 0 || bus_if.mode_out !== 2'd0) begin
      n_fail++; $display("FAIL bounce_result: pulses=%0d mode=%0d want pulses=0 mode=0", pulses, bus_if.mode_out);
    end
    n_chk++;
    for (int p = 0; p < 4; p++) begin
      pulses = 0;
      btn_raw = 1'b1;
      for (int i = 0; i < 10; i++) begin
        step();
        if (bus_if.btn_pulse === 1'b1) pulses++;
        if ({bus_if.led, bus_if.mode_out, bus_if.btn_pulse} !== {m_led, 2'(m_mode), m_pulse}) begin
          n_fail++;
          $display("FAIL press: mode=%0d pulse=%b, want mode=%0d pulse=%b", bus_if.mode_out, bus_if.btn_pulse, m_mode, m_pulse);
        end
        n_chk++;
      end
      if (pulses != 1 || bus_if.mode_out !== 2'((p + 1) % 4)) begin
        n_fail++; $display("FAIL press_result%0d: pulses=%0d mode=%0d want pulses=1 mode=%0d",
                           p, pulses, bus_if.mode_out, (p + 1) % 4);
      end
      n_chk++;
      btn_raw = 1'b0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (bus_if.btn_pulse !== 1'b0) begin
          n_fail++; $display("FAIL release: pulse=%b want 0", bus_if.btn_pulse);
        end
        n_chk++;
      end
    end
  endtask

  task automatic test_priority();
    bit found = 0;
    btn_raw = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus_if.btn_pulse === 1'b1) found = 1;
    end
    if (!found) begin
      n_fail++; $display("FAIL prio_wait: btn_pulse not seen within 20 cycles");
    end
    n_chk++;
    bus_if.mode_load = 1'b1; bus_if.mode_in = 2'd3;
    step();
    bus_if.mode_load = 1'b0;
    btn_raw = 1'b0;
    if (bus_if.mode_out !== 2'd3 || bus_if.mode_out !== 2'(m_mode)) begin
      n_fail++; $display("FAIL prio: mode=%0d want 3 (model %0d)", bus_if.mode_out, m_mode);
    end
    n_chk++;
    repeat (10) step();
    reset_rtl_n = 1'b0;
    step();
    if (bus_if.led !== 8'hAB || bus_if.mode_out !== 2'd0 || bus_if.tick !== 1'b0) begin
      n_fail++; $display("FAIL midreset: led=%h mode=%0d tick=%b want led=ab mode=0 tick=0",
                         bus_if.led, bus_if.mode_out, bus_if.tick);
    end
    n_chk++;
    reset_rtl_n = 1'b1;
  endtask

  task automatic test_random();
    int run = 0;
    for (int i = 0; i < 1500; i++) begin
      bus_if.static_pattern = 8'($urandom);
      bus_if.mode_load = ($urandom_range(0, 39) == 0);
      bus_if.mode_in = 2'($urandom);
      reset_rtl_n = ($urandom_range(0, 299) != 0);
      if (run == 0) begin
        btn_raw = ~btn_raw;
        run = $urandom_range(1, 8);
      end
      run--;
      step();
      if ({bus_if.led, bus_if.mode_out, bus_if.tick, bus_if.btn_pulse} !== {m_led, 2'(m_mode), m_tick, m_pulse}) begin
        n_fail++;
        $display("FAIL random cyc%0d: led=%h mode=%0d tick=%b pulse=%b, want led=%h mode=%0d tick=%b pulse=%b",
                 i, bus_if.led, bus_if.mode_out, bus_if.tick, bus_if.btn_pulse, m_led, m_mode, m_tick, m_pulse);
      end
      n_chk++;
    end
    bus_if.mode_load = 1'b0;
    reset_rtl_n = 1'b1;
  endtask

  initial begin
    reset_rtl_n = 1'b0;
    btn_raw = 1'b0;
    bus_if.mode_load = 1'b0;
    bus_if.mode_in = 2'd0;
    bus_if.static_pattern = 8'h00;
    #2;
    test_reset();
    test_static();
    test_heartbeat();
    test_walk();
    test_count();
    test_debounce();
    test_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/zed_status_leds.md
# zed_status_leds

Parametrised board-status LED engine for the Zed top level, replacing the fixed LED constant drive with a programmable pattern generator. It drives NUM_LEDS outputs in one of four modes (static, heartbeat, walking-one, binary count) paced by an internal prescaler. The active mode is selected by a debounced push-button or a direct load from fabric logic. It sits beside the PS wrapper in the top and exists so a live design is visually distinguishable from a hung one.

## Interface
- NUM_LEDS, 8, number of LED outputs (≥2)
- TICK_DIV, 50_000_000, GCLK cycles per pattern tick (≥2)
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a button level change (≥1)
- STATIC_RESET, 'hAB, value driven on led during reset (NUM_LEDS bits)
- GCLK  input  1  system clock, 100 MHz; single clock domain
- reset_rtl_n  input  1  synchronous, active-low reset
- btn_raw  input  1  asynchronous, bouncing push-button, active high
- mode_load  input  1  load mode_in into the mode register this cycle
- mode_in  input  2  mode to load (0 static, 1 heartbeat, 2 walk, 3 count)
- static_pattern  input  NUM_LEDS  pattern shown in static mode
- led  output  NUM_LEDS  registered LED drive
- mode_out  output  2  current mode register
- tick  output  1  one-cycle pulse per prescaler wrap
- btn_pulse  output  1  one-cycle pulse on debounced button press

## Operation
- Prescaler: counter 0..TICK_DIV-1, +1 per cycle; at TICK_DIV-1 it wraps to 0 and tick=1 that cycle.
- Button path: 2-FF synchroniser → debouncer. Debounced level toggles only after synced input differs from it for DEBOUNCE_CYCLES consecutive cycles; any cycle where they match clears the stability counter. btn_pulse=1 for one cycle when debounced level goes 0→1; no pulse on release.
- Mode register: mode_load=1 → mode_in; else btn_pulse=1 → (mode+1) mod 4 (3 wraps to 0); else hold. mode_load wins over btn_pulse in the same cycle (the press is dropped).
- Mode change = any cycle the mode register is written with a different value; loading the current mode is not a change.
- Pattern register (drives led), per cycle, priority order:
  - Mode change: initialise for the new mode: static → static_pattern; heartbeat → all zeros; walk → bit 0 set only; count → zero. A tick in the same cycle is ignored.
  - Static: led ← static_pattern every cycle (tick irrelevant).
  - Heartbeat: on tick, invert all bits.
  - Walk: on tick, rotate left by 1; MSB wraps to bit 0.
  - Count: on tick, +1 modulo 2^NUM_LEDS (all-ones → zero).
  - No tick: hold.

## Timing
- Reset (reset_rtl_n=0 at a GCLK edge): led=STATIC_RESET, mode_out=0, tick=0, btn_pulse=0, prescaler=0, synchroniser/debounced level=0, stability counter=0. Reset mid-pattern aborts immediately; no residual state.
- First tick: TICK_DIV cycles after the first edge with reset_rtl_n=1, then every TICK_DIV cycles.
- Static: led reflects static_pattern one cycle after it is sampled; first post-reset cycle replaces STATIC_RESET.
- Pattern update on tick: led changes at the edge after the cycle tick=1 (1-cycle latency).
- mode_load: mode_out and initialised led both visible the cycle after the loading edge.
- Button: stable press of btn_raw → btn_pulse 2 (sync) + DEBOUNCE_CYCLES cycles later, ±1; mode_out advances one cycle after btn_pulse.
- Bounce shorter than DEBOUNCE_CYCLES produces no pulse.

## Test plan
- Reset/static: NUM_LEDS=8, hold reset_rtl_n=0 → led=0xAB, mode_out=0; release with static_pattern=0x3C → led=0x3C next cycle; change to 0x81 → led=0x81 one cycle later.
- Heartbeat: TICK_DIV=4, mode_load=1, mode_in=1 → led=0x00; after ticks at post-load cycles 4/8/12 → 0xFF, 0x00, 0xFF; tick period exactly 4 cycles.
- Walk wrap: mode_in=2, TICK_DIV=4 → led 0x01, 0x02, …, 0x80, then 0x01 after the 8th tick.
- Count wrap and tick collision: mode_in=3, run 256 ticks → 0x00…0xFF→0x00; issue mode_load (mode 2) in a tick cycle → led=0x01, not 0x02.
- Debounce: DEBOUNCE_CYCLES=3, btn_raw toggled 1-0-1-0 each cycle → no btn_pulse, mode unchanged; then held high 10 cycles → exactly one btn_pulse, mode 0→1; release and re-press ×3 → mode 2,3,0.
- Priority/reset: btn_pulse and mode_load (mode_in=3) in the same cycle → mode_out=3; assert reset_rtl_n=0 mid-count → led=0xAB, mode_out=0 at the next edge.
